menu_select: RTL

//   Parametrised N-entry menu cursor controller for the start/pause screens.

---
 rtl/menu_select_pkg.sv | 38 +++
 rtl/menu_select_btn_debounce.sv | 44 ++++
 rtl/menu_select.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/menu_select_pkg.sv
// Shared state encoding, default menu geometry and cursor-step helper for the
// start/pause menu cursor controller.
package menu_select_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_NAV     = 2'd1,
      ST_CONFIRM = 2'd2,
      ST_LOCK    = 2'd3
   } menu_state_t;

   localparam int DEF_N_ITEMS         = 2;
   localparam int DEF_ITEM_Y0         = 201;
   localparam int DEF_ITEM_PITCH      = 55;
   localparam int DEF_ARROW_X1        = 188;
   localparam int DEF_ARROW_X2        = 218;
   localparam int DEF_ARROW_SIZE      = 26;
   localparam int DEF_WRAP            = 1;
   localparam int DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int DEF_REPEAT_DELAY    = 50000000;
   localparam int DEF_REPEAT_RATE     = 15000000;

   // One cursor step; at either end the cursor wraps or saturates.
   function automatic int step_idx(input int idx, input int n, input logic dn,
                                   input logic wrap);
      int r;
      r = idx;
      if (dn) begin
         if (idx == n - 1) r = wrap ? 0 : idx;
         else              r = idx + 1;
      end else begin
         if (idx == 0) r = wrap ? n - 1 : idx;
         else          r = idx - 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/menu_select_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-sample counter and a one-clk
// pulse on the rising edge of the debounced level.
module menu_select_btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    sync;
   logic          level_q;
   logic [CW-1:0] cnt;

   // The level flips once DEBOUNCE_CYCLES consecutive samples disagree with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync    <= '0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
      end else begin
         sync    <= {sync[0], raw};
         level_q <= level;
         if (sync[1] != level) begin
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               level <= sync[1];
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign rise = level & ~level_q;

endmodule

// File: rtl/menu_select.sv
// N-entry menu cursor controller with held sel_valid/sel_ack handshake and a
// pixel-tick registered arrow. Define AUTOREPEAT_EN to enable held-button auto-stepping.
module menu_select
   import menu_select_pkg::*;
#(
   parameter int N_ITEMS         = DEF_N_ITEMS,
   parameter int ITEM_Y0         = DEF_ITEM_Y0,
   parameter int ITEM_PITCH      = DEF_ITEM_PITCH,
   parameter int ARROW_X1        = DEF_ARROW_X1,
   parameter int ARROW_X2        = DEF_ARROW_X2,
   parameter int ARROW_SIZE      = DEF_ARROW_SIZE,
   parameter int WRAP            = DEF_WRAP,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
   parameter int IDX_W           = $clog2(N_ITEMS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             up,
   input  logic             down,
   input  logic             enter,
   input  logic             menu_active,
   input  logic             p_tick,
   input  logic [9:0]       x,
   input  logic [9:0]       y,
   input  logic             sel_ack,
   output logic [IDX_W-1:0] cursor_idx,
   output logic [9:0]       cursor_y,
   output logic             sel_valid,
   output logic [IDX_W-1:0] sel_idx,
   output logic             arrow_on
);

   logic up_lvl, up_rise, dn_lvl, dn_rise, en_lvl, en_rise;
   logic step_up, step_dn;

   menu_select_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk(clk), .reset(reset), .raw(up), .level(up_lvl), .rise(up_rise));
   menu_select_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
      .clk(clk), .reset(reset), .raw(down), .level(dn_lvl), .rise(dn_rise));
   menu_select_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_en (
      .clk(clk), .reset(reset), .raw(enter), .level(en_lvl), .rise(en_rise));

   menu_state_t      state, state_nxt;
   logic [IDX_W-1:0] idx_nxt, sel_idx_nxt;
   logic             sel_valid_nxt;

`ifdef AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   logic [RW-1:0] rep_cnt;
   logic          rep_first, rep_cond, rep_hit;

   // rep_cnt is 0 on the cycle the press event is consumed, so the first
   // auto-step lands REPEAT_DELAY clks after it, later ones every REPEAT_RATE.
   assign rep_cond = (state == ST_NAV) && menu_active && (up_lvl ^ dn_lvl) && !en_rise;
   assign rep_hit  = rep_cond &&
                     (rep_cnt == (rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if (!rep_cond) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if (rep_hit) begin
         rep_cnt   <= RW'(1);
         rep_first <= 1'b0;
      end else begin
         rep_cnt <= rep_cnt + RW'(1);
      end
   end

   assign step_up = up_rise | (rep_hit & up_lvl);
   assign step_dn = dn_rise | (rep_hit & dn_lvl);
`else
   logic unused_rep;
   assign unused_rep = up_lvl ^ dn_lvl ^ (REPEAT_DELAY == REPEAT_RATE);
   assign step_up    = up_rise;
   assign step_dn    = dn_rise;
`endif

   always_comb begin
      state_nxt     = state;
      idx_nxt       = cursor_idx;
      sel_valid_nxt = sel_valid;
      sel_idx_nxt   = sel_idx;
      if (!menu_active) begin
         state_nxt     = ST_IDLE;
         sel_valid_nxt = 1'b0;
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_NAV;
            ST_NAV: begin
               if (en_rise) begin
                  sel_idx_nxt   = cursor_idx;
                  sel_valid_nxt = 1'b1;
                  state_nxt     = ST_CONFIRM;
               end else if (step_up ^ step_dn) begin
                  idx_nxt = IDX_W'(step_idx(int'(cursor_idx), N_ITEMS, step_dn, WRAP != 0));
               end
            end
            ST_CONFIRM: begin
               if (sel_ack) begin
                  sel_valid_nxt = 1'b0;
                  state_nxt     = ST_LOCK;
               end
            end
            ST_LOCK: if (!en_lvl) state_nxt = ST_NAV;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cursor_idx <= '0;
         cursor_y   <= 10'(ITEM_Y0);
         sel_valid  <= 1'b0;
         sel_idx    <= '0;
      end else begin
         state      <= state_nxt;
         cursor_idx <= idx_nxt;
         cursor_y   <= 10'(ITEM_Y0 + int'(idx_nxt) * ITEM_PITCH);
         sel_valid  <= sel_valid_nxt;
         sel_idx    <= sel_idx_nxt;
      end
   end

   // 11-bit bottom bound so cursor_y+ARROW_SIZE cannot wrap.
   logic [10:0] arrow_bot;
   assign arrow_bot = {1'b0, cursor_y} + 11'(ARROW_SIZE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         arrow_on <= 1'b0;
      end else if (p_tick) begin
         arrow_on <= (x > 10'(ARROW_X1)) && (x < 10'(ARROW_X2)) &&
                     (y > cursor_y) && ({1'b0, y} < arrow_bot);
      end
   end

endmodule
